// File: rtl/bus_pkg.sv
// Shared constants for the CPU bus: default bus geometry and the fixed
// source numbering used by the control unit's *out enables.
package bus_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_NUM_SRC = 24;

    localparam int SRC_R0     = 0;
    localparam int SRC_R1     = 1;
    localparam int SRC_R2     = 2;
    localparam int SRC_R3     = 3;
    localparam int SRC_R4     = 4;
    localparam int SRC_R5     = 5;
    localparam int SRC_R6     = 6;
    localparam int SRC_R7     = 7;
    localparam int SRC_R8     = 8;
    localparam int SRC_R9     = 9;
    localparam int SRC_R10    = 10;
    localparam int SRC_R11    = 11;
    localparam int SRC_R12    = 12;
    localparam int SRC_R13    = 13;
    localparam int SRC_R14    = 14;
    localparam int SRC_R15    = 15;
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHI    = 18;
    localparam int SRC_ZLO    = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int SRC_CSIGN  = 23;

endpackage

// File: rtl/onehot_prio_enc.sv
// Lowest-index-wins priority encoder over a nominally one-hot request vector,
// also flagging "anything asserted" and "more than one asserted".
module onehot_prio_enc #(
    parameter int N     = 24,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign any   = |req;
    assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/bus_mux_reg.sv
// Registered CPU bus multiplexer: priority-resolved source select, idle hold,
// and sticky contention detection with a saturating event counter.
module bus_mux_reg
    import bus_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int NUM_SRC   = DEFAULT_NUM_SRC,
    parameter int SEL_W     = $clog2(NUM_SRC),
    parameter bit HOLD_IDLE = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_out,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         bus_out,
    output logic [SEL_W-1:0]         bus_sel,
    output logic                     bus_valid,
    output logic                     contention,
    output logic [CNT_W-1:0]         contention_cnt
);

    logic [WIDTH-1:0] w_words [NUM_SRC];
    logic [SEL_W-1:0] w_sel;
    logic             w_any;
    logic             w_multi;

    logic [WIDTH-1:0] r_busOut;
    logic [SEL_W-1:0] r_busSel;
    logic             r_busValid;
    logic             r_contention;
    logic [CNT_W-1:0] r_contentionCnt;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign w_words[g] = src_data[g*WIDTH +: WIDTH];
    end

    onehot_prio_enc #(
        .N     (NUM_SRC),
        .IDX_W (SEL_W)
    ) u_enc (
        .req   (src_out),
        .idx   (w_sel),
        .any   (w_any),
        .multi (w_multi)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_busOut   <= '0;
            r_busSel   <= '0;
            r_busValid <= 1'b0;
        end else if (w_any) begin
            r_busOut   <= w_words[w_sel];
            r_busSel   <= w_sel;
            r_busValid <= 1'b1;
        end else begin
            r_busValid <= 1'b0;
            if (!HOLD_IDLE) begin
                r_busOut <= '0;
            end
        end
    end

    // A fresh contention event outranks a simultaneous clear, restarting the count at one.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_contention    <= 1'b0;
            r_contentionCnt <= '0;
        end else if (w_multi) begin
            r_contention <= 1'b1;
            if (clr_err) begin
                r_contentionCnt <= CNT_W'(1);
            end else if (r_contentionCnt != '1) begin
                r_contentionCnt <= r_contentionCnt + CNT_W'(1);
            end
        end else if (clr_err) begin
            r_contention    <= 1'b0;
            r_contentionCnt <= '0;
        end
    end

    assign bus_out        = r_busOut;
    assign bus_sel        = r_busSel;
    assign bus_valid      = r_busValid;
    assign contention     = r_contention;
    assign contention_cnt = r_contentionCnt;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed self-checking bench for bus_mux_reg: one hold-idle and one
// zero-idle instance share the same stimulus.
module tb_bus_mux_reg;
    import bus_pkg::*;

    localparam int W  = 32;
    localparam int NS = 24;
    localparam int SW = 5;
    localparam int CW = 8;

    logic            clk;
    logic            clrN;
    logic [NS*W-1:0] srcData;
    logic [NS-1:0]   srcOut;
    logic            clrErr;

    logic [W-1:0]  busOutH, busOutZ;
    logic [SW-1:0] busSelH, busSelZ;
    logic          busValidH, busValidZ;
    logic          contH, contZ;
    logic [CW-1:0] cntH, cntZ;

    int checkCount = 0;
    int errorCount = 0;

    bus_mux_reg #(.WIDTH(W), .NUM_SRC(NS), .SEL_W(SW), .HOLD_IDLE(1'b1), .CNT_W(CW)) dutHold (
        .clk(clk), .clr_n(clrN), .src_data(srcData), .src_out(srcOut), .clr_err(clrErr),
        .bus_out(busOutH), .bus_sel(busSelH), .bus_valid(busValidH),
        .contention(contH), .contention_cnt(cntH)
    );

    bus_mux_reg #(.WIDTH(W), .NUM_SRC(NS), .SEL_W(SW), .HOLD_IDLE(1'b0), .CNT_W(CW)) dutZero (
        .clk(clk), .clr_n(clrN), .src_data(srcData), .src_out(srcOut), .clr_err(clrErr),
        .bus_out(busOutZ), .bus_sel(busSelZ), .bus_valid(busValidZ),
        .contention(contZ), .contention_cnt(cntZ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic setWord(input int idx, input logic [W-1:0] value);
        srcData[idx*W +: W] = value;
    endtask

    // Drive one cycle's inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic [NS-1:0] enables, input logic clear);
        srcOut = enables;
        clrErr = clear;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_out"},   busOutH,   32'h0);
        checkOutput({tag, "_sel"},   {27'h0, busSelH}, 32'h0);
        checkOutput({tag, "_valid"}, {31'h0, busValidH}, 32'h0);
        checkOutput({tag, "_cont"},  {31'h0, contH}, 32'h0);
        checkOutput({tag, "_cnt"},   {24'h0, cntH}, 32'h0);
        checkOutput({tag, "_outZ"},  busOutZ,   32'h0);
    endtask

    initial begin
        srcData = '0;
        srcOut  = '0;
        clrErr  = 1'b0;
        clrN    = 1'b1;
        #1 clrN = 1'b0;

        // Reset with arbitrary inputs toggling underneath.
        srcOut = 24'hABCDEF;
        clrErr = 1'b1;
        for (int i = 0; i < NS; i++) setWord(i, 32'hA5A50000 + 32'(i));
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        clrN = 1'b1;
        clrErr = 1'b0;

        setWord(SRC_R5, 32'hDEADBEEF);
        applyStimulus(24'(1) << SRC_R5, 1'b0);
        checkOutput("first_out",   busOutH, 32'hDEADBEEF);
        checkOutput("first_sel",   {27'h0, busSelH}, 32'd5);
        checkOutput("first_valid", {31'h0, busValidH}, 32'd1);
        checkOutput("first_cont",  {31'h0, contH}, 32'd0);

        applyStimulus('0, 1'b0);
        checkOutput("idle_hold_out", busOutH, 32'hDEADBEEF);
        checkOutput("idle_valid",    {31'h0, busValidH}, 32'd0);
        checkOutput("idle_sel",      {27'h0, busSelH}, 32'd5);
        checkOutput("idle_zero_out", busOutZ, 32'h0);
        checkOutput("idle_zero_valid", {31'h0, busValidZ}, 32'd0);

        setWord(SRC_R3, 32'h11);
        setWord(SRC_PC, 32'h400);
        applyStimulus((24'(1) << SRC_R3) | (24'(1) << SRC_PC), 1'b0);
        checkOutput("cont_out",   busOutH, 32'h11);
        checkOutput("cont_sel",   {27'h0, busSelH}, 32'd3);
        checkOutput("cont_flag",  {31'h0, contH}, 32'd1);
        checkOutput("cont_cnt",   {24'h0, cntH}, 32'd1);

        for (int i = 1; i < 300; i++) begin
            applyStimulus((24'(1) << SRC_R3) | (24'(1) << SRC_PC), 1'b0);
            if (i == 253) checkOutput("cnt_254", {24'h0, cntH}, 32'd254);
            if (i == 254) checkOutput("cnt_255", {24'h0, cntH}, 32'd255);
        end
        checkOutput("cnt_sat", {24'h0, cntH}, 32'd255);
        checkOutput("cnt_sat_flag", {31'h0, contH}, 32'd1);

        applyStimulus(24'(1) << SRC_R0, 1'b1);
        checkOutput("clr_flag", {31'h0, contH}, 32'd0);
        checkOutput("clr_cnt",  {24'h0, cntH}, 32'd0);

        applyStimulus(24'b110, 1'b1);
        checkOutput("clr_multi_flag", {31'h0, contH}, 32'd1);
        checkOutput("clr_multi_cnt",  {24'h0, cntH}, 32'd1);
        checkOutput("clr_multi_sel",  {27'h0, busSelH}, 32'd1);

        applyStimulus(24'b110, 1'b0);
        checkOutput("multi_again_cnt", {24'h0, cntH}, 32'd2);

        applyStimulus('0, 1'b1);
        checkOutput("clr_idle_cnt", {24'h0, cntH}, 32'd0);

        for (int i = 0; i < NS; i++) setWord(i, 32'(i) * 32'h01010101);
        for (int i = 0; i < NS; i++) begin
            applyStimulus(24'(1) << i, 1'b0);
            checkOutput($sformatf("sweep%0d_out", i), busOutH, 32'(i) * 32'h01010101);
            checkOutput($sformatf("sweep%0d_sel", i), {27'h0, busSelH}, 32'(i));
            checkOutput($sformatf("sweep%0d_cont", i), {31'h0, contH}, 32'd0);
        end
        checkOutput("sweep_cnt", {24'h0, cntH}, 32'd0);

        setWord(SRC_CSIGN, 32'hFFFFFF80);
        applyStimulus(24'(1) << SRC_CSIGN, 1'b0);
        checkOutput("csign_out", busOutH, 32'hFFFFFF80);
        applyStimulus((24'(1) << SRC_CSIGN) | (24'(1) << SRC_INPORT), 1'b0);
        checkOutput("pre_async_cont", {31'h0, contH}, 32'd1);
        srcOut = 24'(1) << SRC_CSIGN;
        #2 clrN = 1'b0;
        #1;
        checkAllZero("async");
        clrErr = 1'b1;
        @(posedge clk);
        #1;
        checkAllZero("async_hold");
        @(negedge clk);
        clrN = 1'b1;
        applyStimulus(24'(1) << SRC_CSIGN, 1'b0);
        checkOutput("post_rst_out",   busOutH, 32'hFFFFFF80);
        checkOutput("post_rst_sel",   {27'h0, busSelH}, 32'd23);
        checkOutput("post_rst_valid", {31'h0, busValidH}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
